// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing controllers.
// Holds the handshake FSM state encoding and the minimum synchronizer depth.
package cdc_pkg;

  localparam int CDC_MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } cdc_state_e;

endpackage

// File: rtl/sync_stages.sv
// Single-bit multi-flop synchronizer with active-low synchronous reset.
// The output is the input delayed by STAGES destination clock edges.
module sync_stages #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx_ctrl.sv
// Destination side of a 4-phase req/ack crossing: synchronizes req, captures the
// quasi-static data bus into a valid/ready stream and returns a registered ack.
module cdc_hs_rx_ctrl
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              async_req_i,
  input  logic [DATA_W-1:0] async_data_i,
  output logic              async_ack_o,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              proto_err
);

  if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("cdc_hs_rx_ctrl: SYNC_STAGES must be at least %0d", CDC_MIN_SYNC_STAGES);
  end

  cdc_state_e       state, state_n;
  logic             req_s;
  logic             ack_q, ack_n;
  logic             valid_q, valid_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             data_load;

  sync_stages #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (~rst),
    .d     (async_req_i),
    .q     (req_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      ack_q   <= ack_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      cnt_q   <= cnt_n;
    end
  end

  // CDC waiver: async_data_i is deliberately unsynchronized. The source holds it
  // stable while req is high, and it is only loaded once req_s has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
    end else if (data_load) begin
      m_data <= async_data_i;
    end
  end

  always_comb begin
    state_n   = state;
    ack_n     = ack_q;
    valid_n   = valid_q;
    err_n     = err_q;
    cnt_n     = cnt_q;
    data_load = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          data_load = 1'b1;
          valid_n   = 1'b1;
          state_n   = VALID;
        end
      end
      VALID: begin
        // A handshake in the same cycle as a withdrawal still completes the transfer.
        if (valid_q && m_ready) begin
          valid_n = 1'b0;
          ack_n   = 1'b1;
          cnt_n   = cnt_q + CNT_W'(1);
          state_n = ACK;
        end else if (!req_s) begin
          err_n   = 1'b1;
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        ack_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign async_ack_o = ack_q;
  assign m_valid     = valid_q;
  assign xfer_cnt    = cnt_q;
  assign proto_err   = err_q;

endmodule
